// File: rtl/bt656_stream_dec.sv
// rtl/bt656_stream_dec.sv - BT.656 embedded-sync decoder: active-video words, sync flags, line/pixel counters.
// Define BT656_HDR_PROT_EN to check and correct the XY protection bits P3..P0.
module bt656_stream_dec #(
  parameter int DW      = 8,
  parameter int PIX_CW  = 11,
  parameter int LINE_CW = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               en_i,
  input  logic [DW-1:0]      data_i,
  output logic [DW-1:0]      pix_data_o,
  output logic               pix_valid_o,
  output logic               sol_o,
  output logic               sof_o,
  output logic               field_o,
  output logic               vblank_o,
  output logic               hblank_o,
  output logic [PIX_CW-1:0]  pix_cnt_o,
  output logic [LINE_CW-1:0] line_cnt_o,
  output logic [PIX_CW-1:0]  line_len_o,
  output logic               hdr_err_o
);

  typedef enum logic [1:0] {S_DATA, S_FF, S_FF00, S_FF0000} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [7:0]         w_hi;
  logic               w_is_ff;
  logic               w_is_00;
  logic               w_xy;
  logic               w_uncor;
  logic               w_bad;
  logic               w_acc;
  logic               w_valid;
  logic [2:0]         w_fvh;
  logic [PIX_CW-1:0]  w_cnt_inc;
  logic [DW-1:0]      r_pd [4];
  logic [3:0]         r_sq;
  logic               r_field;
  logic               r_v;
  logic               r_h;
  logic               r_sync;
  logic               r_first;
  logic               r_fline;
  logic               r_act;
  logic               r_hdr_err;
  logic [PIX_CW-1:0]  r_pix_cnt;
  logic [PIX_CW-1:0]  r_line_len;
  logic [LINE_CW-1:0] r_line_cnt;

  assign w_hi    = data_i[DW-1 -: 8];
  assign w_is_ff = (w_hi == 8'hFF);
  assign w_is_00 = (w_hi == 8'h00);

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_DATA;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_xy        = 1'b0;
    if (en_i) begin
      case (r_state)
        S_DATA:   w_state_nxt = w_is_ff ? S_FF : S_DATA;
        S_FF:     w_state_nxt = w_is_00 ? S_FF00 : (w_is_ff ? S_FF : S_DATA);
        S_FF00:   w_state_nxt = w_is_00 ? S_FF0000 : (w_is_ff ? S_FF : S_DATA);
        S_FF0000: begin
          w_state_nxt = w_is_ff ? S_FF : S_DATA;
          w_xy        = !w_is_ff;
        end
        default:  w_state_nxt = S_DATA;
      endcase
    end
  end

`ifdef BT656_HDR_PROT_EN
  logic [3:0] w_syn;
  // Syndrome = received parity vs parity recomputed from received F/V/H.
  assign w_syn = w_hi[3:0] ^ {w_hi[5] ^ w_hi[4], w_hi[6] ^ w_hi[4],
                              w_hi[6] ^ w_hi[5], w_hi[6] ^ w_hi[5] ^ w_hi[4]};
  always_comb begin
    w_fvh   = w_hi[6:4];
    w_uncor = 1'b0;
    case (w_syn)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000: ;
      4'b0111: w_fvh[2] = ~w_hi[6];
      4'b1011: w_fvh[1] = ~w_hi[5];
      4'b1101: w_fvh[0] = ~w_hi[4];
      default: w_uncor  = 1'b1;
    endcase
  end
`else
  assign w_fvh   = w_hi[6:4];
  assign w_uncor = 1'b0;
`endif

  assign w_bad     = w_xy && (!w_hi[7] || w_uncor);
  assign w_acc     = w_xy && !w_bad;
  assign w_valid   = !r_sq[3] && r_sync && !r_h && !r_v;
  assign w_cnt_inc = r_pix_cnt + PIX_CW'(w_valid && (r_pix_cnt != '1));

  // A squash flag follows each word; an accepted XY marks itself and the preamble ahead of it.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) r_pd[i] <= '0;
      r_sq <= '0;
    end else if (en_i) begin
      r_pd[0] <= data_i;
      for (int i = 1; i < 4; i++) r_pd[i] <= r_pd[i-1];
      r_sq <= {r_sq[2:0], 1'b0} | {4{w_acc}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_field    <= 1'b0;
      r_v        <= 1'b0;
      r_h        <= 1'b0;
      r_sync     <= 1'b0;
      r_first    <= 1'b0;
      r_fline    <= 1'b0;
      r_act      <= 1'b0;
      r_hdr_err  <= 1'b0;
      r_pix_cnt  <= '0;
      r_line_len <= '0;
      r_line_cnt <= '0;
    end else begin
      r_hdr_err <= w_bad;
      if (en_i) begin
        r_pix_cnt <= w_cnt_inc;
        if (w_valid) begin
          r_first <= 1'b0;
          r_fline <= 1'b0;
        end
        if (w_acc) begin
          {r_field, r_v, r_h} <= w_fvh;
          if (!w_fvh[0]) begin
            r_sync    <= 1'b1;
            r_first   <= 1'b1;
            r_pix_cnt <= '0;
            r_act     <= !w_fvh[1];
          end else begin
            if (r_act) r_line_len <= w_cnt_inc;
            r_act <= 1'b0;
          end
          if (w_fvh[2] != r_field) begin
            r_line_cnt <= '0;
            r_fline    <= 1'b1;
          end else if (w_fvh[0]) begin
            r_line_cnt <= r_line_cnt + LINE_CW'(1);
          end
        end
      end
    end
  end

  assign pix_data_o  = r_pd[3];
  assign pix_valid_o = w_valid;
  assign sol_o       = w_valid && r_first;
  assign sof_o       = w_valid && r_first && r_fline && !r_field;
  assign field_o     = r_field;
  assign vblank_o    = r_v;
  assign hblank_o    = r_h;
  assign pix_cnt_o   = r_pix_cnt;
  assign line_cnt_o  = r_line_cnt;
  assign line_len_o  = r_line_len;
  assign hdr_err_o   = r_hdr_err;

endmodule

// File: tb/tb_bt656_stream_dec.sv
// tb/tb_bt656_stream_dec.sv - scoreboard bench for bt656_stream_dec.
// Honours BT656_HDR_PROT_EN when deciding which XY words are accepted.
module tb_bt656_stream_dec;
  localparam int DW      = 8;
  localparam int PIX_CW  = 11;
  localparam int LINE_CW = 10;

  logic               clk_i = 1'b0;
  logic               rst_i;
  logic               en_i;
  logic [DW-1:0]      data_i;
  logic [DW-1:0]      pix_data_o;
  logic               pix_valid_o;
  logic               sol_o;
  logic               sof_o;
  logic               field_o;
  logic               vblank_o;
  logic               hblank_o;
  logic [PIX_CW-1:0]  pix_cnt_o;
  logic [LINE_CW-1:0] line_cnt_o;
  logic [PIX_CW-1:0]  line_len_o;
  logic               hdr_err_o;

  bt656_stream_dec #(.DW(DW), .PIX_CW(PIX_CW), .LINE_CW(LINE_CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .data_i(data_i),
    .pix_data_o(pix_data_o), .pix_valid_o(pix_valid_o), .sol_o(sol_o), .sof_o(sof_o),
    .field_o(field_o), .vblank_o(vblank_o), .hblank_o(hblank_o),
    .pix_cnt_o(pix_cnt_o), .line_cnt_o(line_cnt_o), .line_len_o(line_len_o),
    .hdr_err_o(hdr_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [7:0] d;
    logic       sol;
    logic       sof;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  bit mf, mv, mh, msync, mfirst, mfline, mact;
  int mline, mcnt, mlen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
    end
  endtask

  function automatic void decode(input logic [7:0] xy, output bit ok, output logic [2:0] fvh);
`ifdef BT656_HDR_PROT_EN
    logic [7:0] cw [8] = '{8'h80, 8'h9D, 8'hAB, 8'hB6, 8'hC7, 8'hDA, 8'hEC, 8'hF1};
    ok  = 1'b0;
    fvh = 3'b000;
    for (int i = 0; i < 8; i++) begin
      if (xy[7] && ($countones(xy ^ cw[i]) <= 1)) begin
        ok  = 1'b1;
        fvh = cw[i][6:4];
      end
    end
`else
    ok  = xy[7];
    fvh = xy[6:4];
`endif
  endfunction

  task automatic drive(input logic [7:0] d, input logic e = 1'b1);
    data_i = d;
    en_i   = e;
    @(posedge clk_i);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d);
    if (msync && !mh && !mv) begin
      sb.push_back('{d: d, sol: mfirst, sof: mfirst && mfline && !mf});
      mfirst = 1'b0;
      mfline = 1'b0;
      mcnt++;
    end
    drive(d);
  endtask

  task automatic send_hdr(input logic [7:0] xy, input string tag, input int stall = 0);
    bit         ok;
    logic [2:0] fvh;
    drive(8'hFF);
    drive(8'h00);
    for (int i = 0; i < stall; i++) drive(8'h12, 1'b0);
    if (stall > 0) begin
      check({tag, ".stall_hblank"}, 32'(hblank_o), 32'(mh));
      check({tag, ".stall_err"}, 32'(hdr_err_o), 32'(0));
    end
    drive(8'h00);
    decode(xy, ok, fvh);
    if (ok) begin
      if (!fvh[0]) begin
        msync  = 1'b1;
        mfirst = 1'b1;
        mcnt   = 0;
        mact   = !fvh[1];
      end else begin
        if (mact) mlen = mcnt;
        mact = 1'b0;
      end
      if (fvh[2] != mf) begin
        mline  = 0;
        mfline = 1'b1;
      end else if (fvh[0]) begin
        mline = (mline + 1) % (1 << LINE_CW);
      end
      {mf, mv, mh} = fvh;
    end
    drive(xy);
    check({tag, ".hdr_err"}, 32'(hdr_err_o), 32'(!ok));
    check({tag, ".field"},   32'(field_o),   32'(mf));
    check({tag, ".vblank"},  32'(vblank_o),  32'(mv));
    check({tag, ".hblank"},  32'(hblank_o),  32'(mh));
    check({tag, ".line_cnt"}, 32'(line_cnt_o), 32'(mline));
    check({tag, ".line_len"}, 32'(line_len_o), 32'(mlen));
    check({tag, ".pix_cnt"},  32'(pix_cnt_o),  32'(mcnt));
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    drive(8'hFF);
    drive(8'hFF);
    check({tag, ".pix_data"},  32'(pix_data_o),  32'(0));
    check({tag, ".pix_valid"}, 32'(pix_valid_o), 32'(0));
    check({tag, ".sol_sof"},   32'({sol_o, sof_o}), 32'(0));
    check({tag, ".fvh"},       32'({field_o, vblank_o, hblank_o}), 32'(0));
    check({tag, ".pix_cnt"},   32'(pix_cnt_o),  32'(0));
    check({tag, ".line_cnt"},  32'(line_cnt_o), 32'(0));
    check({tag, ".line_len"},  32'(line_len_o), 32'(0));
    check({tag, ".hdr_err"},   32'(hdr_err_o),  32'(0));
    sb.delete();
    {mf, mv, mh, msync, mfirst, mfline, mact} = '0;
    mline = 0;
    mcnt  = 0;
    mlen  = 0;
    rst_i = 1'b0;
  endtask

  always @(negedge clk_i) begin
    if (!rst_i && en_i) begin
      if (pix_valid_o) begin
        if (sb.size() == 0) begin
          check("pix_valid_unexpected", 32'(pix_valid_o), 32'(0));
        end else begin
          mon_e = sb.pop_front();
          check("pix_data", 32'(pix_data_o), 32'(mon_e.d));
          check("sol", 32'(sol_o), 32'(mon_e.sol));
          check("sof", 32'(sof_o), 32'(mon_e.sof));
        end
      end else begin
        check("sol_sof_idle", 32'({sol_o, sof_o}), 32'(0));
      end
    end
  end

  initial begin
    rst_i  = 1'b1;
    en_i   = 1'b0;
    data_i = '0;
    do_reset("rst0");

    send_hdr(8'h80, "sav1");
    for (int i = 0; i < 10; i++) send_word(8'(8'h11 + i));
    send_hdr(8'h9D, "eav1");
    check("line_len_10", 32'(line_len_o), 32'(10));
    for (int i = 0; i < 2; i++) begin
      send_word(8'h80);
      send_word(8'h10);
    end

    send_hdr(8'h55, "bad55");
    send_word(8'h10);
    check("hdr_err_pulse", 32'(hdr_err_o), 32'(0));

    send_word(8'hFF);
    send_hdr(8'h80, "dupff_blank");
    for (int i = 0; i < 4; i++) send_word(8'(8'h21 + i));
    send_word(8'hFF);
    send_hdr(8'h80, "dupff_act");
    for (int i = 0; i < 3; i++) send_word(8'(8'h31 + i));
    send_hdr(8'h9D, "eav2");
    check("line_len_3", 32'(line_len_o), 32'(3));

    send_hdr(8'hDA, "f1_eav");
    send_hdr(8'hC7, "f1_sav");
    send_word(8'h41);
    send_word(8'h42);
    send_hdr(8'hDA, "f1_eav2");
    send_hdr(8'h9D, "f0_eav");
    send_hdr(8'h80, "f0_sav");
    send_word(8'h51);
    send_word(8'h52);
    send_hdr(8'h9D, "f0_eav2");

    send_hdr(8'h8F, "xy8f");
    send_hdr(8'h81, "xy81");
    send_word(8'h61);
    send_word(8'h62);
    send_hdr(8'h9D, "eav_p");

    send_word(8'h10);
    send_hdr(8'h80, "stall_sav", 3);
    for (int i = 0; i < 8; i++) send_word(8'(8'h71 + i));
    do_reset("rst_mid");
    for (int i = 0; i < 6; i++) send_word(8'(8'h90 + i));
    send_hdr(8'h9D, "eav_nosync");
    send_word(8'h96);
    send_word(8'h97);
    send_hdr(8'h80, "sav_resync");
    send_word(8'hA1);
    send_word(8'hA2);
    send_hdr(8'h9D, "eav_end");
    for (int i = 0; i < 4; i++) send_word(8'h10);

    check("sb_empty", 32'(sb.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bt656_stream_dec.md
BT656_STREAM_DEC -- requirements
Module: bt656_stream_dec

Interface
REQ-001 SHALL have parameter DW, default 8, meaning input word width (8 or 10); header codes are compared on the upper 8 bits.
REQ-002 SHALL have parameter PIX_CW, default 11, meaning pixel/byte counter width.
REQ-003 SHALL have parameter LINE_CW, default 10, meaning line counter width.
REQ-004 SHALL have port clk_i  in  1  single clock (the LLC domain); one clock and reset is synchronous and active-high.
REQ-005 SHALL have port rst_i  in  1  synchronous active-high reset.
REQ-006 SHALL have port en_i  in  1  input word qualifier; en_i=0 stalls all state.
REQ-007 SHALL have port data_i  in  DW  BT.656 stream word.
REQ-008 SHALL have port pix_data_o  out  DW  active-video word.
REQ-009 SHALL have port pix_valid_o  out  1  pix_data_o qualifier.
REQ-010 SHALL have port sol_o  out  1  one-cycle pulse with the first active word of a line.
REQ-011 SHALL have port sof_o  out  1  one-cycle pulse with the first active word of field 0.
REQ-012 SHALL have port field_o, vblank_o, hblank_o  out  1 each  last accepted F/V/H bits.
REQ-013 SHALL have port pix_cnt_o  out  PIX_CW  active words since SAV.
REQ-014 SHALL have port line_cnt_o  out  LINE_CW  lines since start of field.
REQ-015 SHALL have port line_len_o  out  PIX_CW  active words of last completed line.
REQ-016 SHALL have port hdr_err_o  out  1  one-cycle pulse on rejected header.

Function
REQ-017 SHALL track the preamble with states S_DATA, S_FF, S_FF00, S_FF0000; transitions occur only when en_i=1.
REQ-018 SHALL go S_DATA->S_FF on 0xFF, S_FF->S_FF00 on 0x00, S_FF00->S_FF0000 on 0x00, and S_FF0000->S_DATA on any word (XY).
REQ-019 SHALL go to S_FF on 0xFF in S_FF, S_FF00 or S_FF0000 (preamble restart); any other mismatch returns to S_DATA.
REQ-020 SHALL accept XY as a header only if bit7=1; bit7=0 SHALL pulse hdr_err_o and leave F/V/H unchanged.
REQ-021 SHALL delay data through a 4-stage enabled pipeline; on header acceptance the three preamble words and XY SHALL be squashed and never presented.
REQ-022 SHALL assert pix_valid_o for a word only when H=0, V=0 and the word is not squashed; latency from data_i to pix_data_o is 4 enabled cycles.
REQ-023 SHALL update field_o/vblank_o/hblank_o one cycle after the accepted XY word.
REQ-024 SHALL clear pix_cnt_o on SAV (H=0) and increment it per valid word, saturating at 2^PIX_CW-1.
REQ-025 SHALL latch line_len_o from pix_cnt_o on each EAV (H=1) that follows an active line, and increment line_cnt_o (wrapping at 2^LINE_CW) on every EAV.
REQ-026 SHALL clear line_cnt_o on an accepted header whose F bit differs from field_o.
REQ-027 SHALL pulse sol_o with the first valid word after SAV, and sof_o additionally when field_o=0 and it is the first active line of that field.
REQ-028 When a header and an invalid XY occur at once (REQ-020), hdr_err_o SHALL win and counters SHALL hold.

Reset
REQ-029 SHALL, while rst_i=1, force state S_DATA, clear the pipeline, and drive every output to 0, including pix_data_o.
REQ-030 SHALL treat reset mid-line as loss of sync: no pix_valid_o until the next accepted SAV.

Configuration
REQ-031 SHALL, with macro BT656_HDR_PROT_EN defined, check P3..P0 (P3=V^H, P2=F^H, P1=F^V, P0=F^V^H), correct single-bit errors per BT.656 table, and reject uncorrectable headers with hdr_err_o.
REQ-032 SHALL, without BT656_HDR_PROT_EN, ignore P3..P0 and accept any XY with bit7=1.

Verification
REQ-033 SHALL verify: FF 00 00 80, then 10 words 0x11..0x1A, then FF 00 00 9D -> pix_valid_o for 10 cycles with 0x11..0x1A at +4 latency, sol_o on 0x11, and line_len_o=10 after EAV.
REQ-034 SHALL verify: FF 00 00 0x55 (bit7=0) -> hdr_err_o one pulse, no flag change, and no squash beyond standard handling.
REQ-035 SHALL verify: FF FF 00 00 80 -> single SAV accepted, and the first FF is emitted as data only if in active region.
REQ-036 SHALL verify: field change 0->1->0 over 3 headers -> line_cnt_o cleared at each change, and sof_o only in field 0.
REQ-037 SHALL verify, with BT656_HDR_PROT_EN: XY=0x81 (P0 flipped from 0x80) -> accepted as SAV; XY=0x8F -> hdr_err_o; without the macro, both are accepted.
REQ-038 SHALL verify: en_i low for 3 cycles mid-preamble, and rst_i asserted mid-line -> state held during the stall; after reset, outputs are 0 and no valid until the next SAV.
